// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file for the pipelined MIPS
//               core. Two write ports (port 1 wins on address collision),
//               NUM_READ combinational read ports, optional hardwired zero
//               register, per-register busy scoreboard and a registered
//               write-back capture of the committed value.
//               Optional macro REGFILE_BYPASS_EN: same-cycle write-through
//               bypass on the read ports (write-first behaviour).
// Revision    : 1.0 - initial multi-port release
// ============================================================================
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                             CLOCK,
  input  logic                             RESET,
  input  logic [NUM_READ*AW-1:0]           RdAddr_IN,
  output logic [NUM_READ*DATA_WIDTH-1:0]   RdData_OUT,
  output logic [NUM_READ-1:0]              RdBusy_OUT,
  input  logic                             WrEn0_IN,
  input  logic [AW-1:0]                    WrAddr0_IN,
  input  logic [DATA_WIDTH-1:0]            WrData0_IN,
  input  logic                             WrEn1_IN,
  input  logic [AW-1:0]                    WrAddr1_IN,
  input  logic [DATA_WIDTH-1:0]            WrData1_IN,
  input  logic                             BusySet_IN,
  input  logic [AW-1:0]                    BusySetAddr_IN,
  output logic                             WBValid_OUT,
  output logic [AW-1:0]                    WBRegister_OUT,
  output logic [DATA_WIDTH-1:0]            WBRegisterValue_OUT
);

  // One extra bit so that DEPTH itself is representable for the range check.
  localparam logic [AW:0] c_depthLimit = (AW+1)'(DEPTH);

  // An address is usable when it lies inside the array and is not the
  // hardwired zero register.
  function automatic logic addrOk(input logic [AW-1:0] addr);
    logic inRange;
    inRange = ({1'b0, addr} < c_depthLimit);
    return inRange && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busyNext;
  logic                  w_wr0Eff;
  logic                  w_wr1Eff;
  logic                  w_busySetEff;

  // Port 0 is dropped when port 1 commits to the same register.
  assign w_wr1Eff     = WrEn1_IN && addrOk(WrAddr1_IN);
  assign w_wr0Eff     = WrEn0_IN && addrOk(WrAddr0_IN) &&
                        !(w_wr1Eff && (WrAddr0_IN == WrAddr1_IN));
  assign w_busySetEff = BusySet_IN && addrOk(BusySetAddr_IN);

  // Register array storage; reset clears every entry.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr0Eff) r_regs[WrAddr0_IN] <= WrData0_IN;
      if (w_wr1Eff) r_regs[WrAddr1_IN] <= WrData1_IN;
    end
  end

  // Next scoreboard state: writes clear, an issue sets, and the set is
  // applied last so a new producer owns the register over a retiring one.
  always_comb begin
    w_busyNext = r_busy;
    if (w_wr0Eff)     w_busyNext[WrAddr0_IN]     = 1'b0;
    if (w_wr1Eff)     w_busyNext[WrAddr1_IN]     = 1'b0;
    if (w_busySetEff) w_busyNext[BusySetAddr_IN] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  // Write-back capture of the value committed on this edge; address and data
  // hold when nothing commits so downstream can still inspect the last write.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      WBValid_OUT         <= 1'b0;
      WBRegister_OUT      <= '0;
      WBRegisterValue_OUT <= '0;
    end else if (w_wr1Eff) begin
      WBValid_OUT         <= 1'b1;
      WBRegister_OUT      <= WrAddr1_IN;
      WBRegisterValue_OUT <= WrData1_IN;
    end else if (w_wr0Eff) begin
      WBValid_OUT         <= 1'b1;
      WBRegister_OUT      <= WrAddr0_IN;
      WBRegisterValue_OUT <= WrData0_IN;
    end else begin
      WBValid_OUT         <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [AW-1:0]         w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_busy;

      assign w_addr = RdAddr_IN[k*AW +: AW];

      // Combinational read; unusable addresses read as zero and not busy.
      always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (addrOk(w_addr)) begin
          w_data = r_regs[w_addr];
          w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
          if (w_wr1Eff && (WrAddr1_IN == w_addr)) begin
            w_data = WrData1_IN;
            w_busy = w_busySetEff && (BusySetAddr_IN == w_addr);
          end else if (w_wr0Eff && (WrAddr0_IN == w_addr)) begin
            w_data = WrData0_IN;
            w_busy = w_busySetEff && (BusySetAddr_IN == w_addr);
          end
`endif
        end
      end

      assign RdData_OUT[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign RdBusy_OUT[k]                          = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp (DEPTH=24 so that
//               out-of-range addresses exist, three read ports). Directed
//               scenarios plus randomized traffic against an array model.
//               Honours REGFILE_BYPASS_EN when compiled with it.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 24;
  localparam int NR    = 3;
  localparam int AW    = 5;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic [NR*AW-1:0]  rdAddr;
  logic [NR*DW-1:0]  rdData;
  logic [NR-1:0]     rdBusy;
  logic              wrEn0, wrEn1, busySet;
  logic [AW-1:0]     wrAddr0, wrAddr1, busySetAddr;
  logic [DW-1:0]     wrData0, wrData1;
  logic              wbValid;
  logic [AW-1:0]     wbReg;
  logic [DW-1:0]     wbVal;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] mReg [DEPTH];
  bit            mBusy [DEPTH];
  bit            mWbV;
  logic [AW-1:0] mWbR;
  logic [DW-1:0] mWbD;

  regfile_mp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR), .ZERO_REG(1)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .RdAddr_IN(rdAddr), .RdData_OUT(rdData), .RdBusy_OUT(rdBusy),
    .WrEn0_IN(wrEn0), .WrAddr0_IN(wrAddr0), .WrData0_IN(wrData0),
    .WrEn1_IN(wrEn1), .WrAddr1_IN(wrAddr1), .WrData1_IN(wrData1),
    .BusySet_IN(busySet), .BusySetAddr_IN(busySetAddr),
    .WBValid_OUT(wbValid), .WBRegister_OUT(wbReg), .WBRegisterValue_OUT(wbVal)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic bit okAddr(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (a != '0);
  endfunction

  // What a read port should show right now, given stored state and inputs.
  function automatic void expRead(input logic [AW-1:0] a,
                                  output logic [DW-1:0] d, output bit b);
    d = '0;
    b = 1'b0;
    if (okAddr(a)) begin
      d = mReg[a];
      b = mBusy[a];
`ifdef REGFILE_BYPASS_EN
      if (wrEn1 && wrAddr1 == a) begin
        d = wrData1;
        b = busySet && (busySetAddr == a);
      end else if (wrEn0 && wrAddr0 == a) begin
        d = wrData0;
        b = busySet && (busySetAddr == a);
      end
`endif
    end
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
    mWbV = 1'b0;
    mWbR = '0;
    mWbD = '0;
  endtask

  // Advance one edge: update the model from the current inputs, then move to
  // 1 time unit after the rising edge.
  task automatic tick();
    bit e0, e1;
    e1 = wrEn1 && okAddr(wrAddr1);
    e0 = wrEn0 && okAddr(wrAddr0);
    if (e0) begin mReg[wrAddr0] = wrData0; mBusy[wrAddr0] = 1'b0; end
    if (e1) begin mReg[wrAddr1] = wrData1; mBusy[wrAddr1] = 1'b0; end
    if (busySet && okAddr(busySetAddr)) mBusy[busySetAddr] = 1'b1;
    if (e1)      begin mWbV = 1'b1; mWbR = wrAddr1; mWbD = wrData1; end
    else if (e0) begin mWbV = 1'b1; mWbR = wrAddr0; mWbD = wrData0; end
    else         mWbV = 1'b0;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    wrEn0   = 1'b0;
    wrEn1   = 1'b0;
    busySet = 1'b0;
  endtask

  task automatic setRd(input int k, input logic [AW-1:0] a);
    rdAddr[k*AW +: AW] = a;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle();
    rdAddr = '0; wrAddr0 = '0; wrAddr1 = '0; busySetAddr = '0;
    wrData0 = '0; wrData1 = '0;
    #2 RESET = 1'b0;
    wrEn0 = 1'b1; wrAddr0 = 5; wrData0 = 32'hDEADBEEF;
    busySet = 1'b1; busySetAddr = 5;
    setRd(0, 5);
    @(posedge CLOCK);
    #1;
    vectors++;
    if (rdData[0 +: DW] !== 32'h0 || rdBusy !== '0) begin
      miscompares++;
      $display("FAIL reset_read: got data %h busy %b, expected 0 / 000", rdData[0 +: DW], rdBusy);
    end
    vectors++;
    if (wbValid !== 1'b0 || wbReg !== '0 || wbVal !== '0) begin
      miscompares++;
      $display("FAIL reset_wb: got valid %b reg %0d val %h, expected 0/0/0", wbValid, wbReg, wbVal);
    end
    RESET = 1'b1;
    idle();
    modelReset();
    #1;
    vectors++;
    if (rdData[0 +: DW] !== 32'h0 || rdBusy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_read5: got data %h busy %b, expected 0 / 0", rdData[0 +: DW], rdBusy[0]);
    end
  endtask

  task automatic test_basic_write();
    wrEn0 = 1'b1; wrAddr0 = 3; wrData0 = 32'h12345678;
    setRd(0, 3);
    tick();
    idle();
    #1;
    vectors++;
    if (rdData[0 +: DW] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL basic_read3: got %h, expected 12345678", rdData[0 +: DW]);
    end
    vectors++;
    if (wbValid !== 1'b1 || wbReg !== 5'd3 || wbVal !== 32'h12345678) begin
      miscompares++;
      $display("FAIL basic_wb: got valid %b reg %0d val %h, expected 1/3/12345678", wbValid, wbReg, wbVal);
    end
    tick();
    vectors++;
    if (wbValid !== 1'b0 || wbReg !== 5'd3) begin
      miscompares++;
      $display("FAIL basic_wb_pulse: got valid %b reg %0d, expected 0/3", wbValid, wbReg);
    end
  endtask

  task automatic test_collision();
    wrEn0 = 1'b1; wrAddr0 = 7; wrData0 = 32'hAAAA;
    wrEn1 = 1'b1; wrAddr1 = 7; wrData1 = 32'h5555;
    setRd(1, 7);
    tick();
    idle();
    #1;
    vectors++;
    if (rdData[DW +: DW] !== 32'h5555) begin
      miscompares++;
      $display("FAIL collision_read7: got %h, expected 00005555", rdData[DW +: DW]);
    end
    vectors++;
    if (wbValid !== 1'b1 || wbReg !== 5'd7 || wbVal !== 32'h5555) begin
      miscompares++;
      $display("FAIL collision_wb: got valid %b reg %0d val %h, expected 1/7/00005555", wbValid, wbReg, wbVal);
    end
  endtask

  task automatic test_zero_reg();
    wrEn0 = 1'b1; wrAddr0 = 0; wrData0 = 32'hFFFFFFFF;
    busySet = 1'b1; busySetAddr = 0;
    setRd(0, 0);
    tick();
    idle();
    #1;
    vectors++;
    if (rdData[0 +: DW] !== 32'h0 || rdBusy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_read: got data %h busy %b, expected 0 / 0", rdData[0 +: DW], rdBusy[0]);
    end
    vectors++;
    if (wbValid !== 1'b0 || wbReg !== 5'd7 || wbVal !== 32'h5555) begin
      miscompares++;
      $display("FAIL zero_wb_hold: got valid %b reg %0d val %h, expected 0/7/00005555", wbValid, wbReg, wbVal);
    end
    // Addresses beyond DEPTH are ignored for writes, busy-set and reads.
    wrEn1 = 1'b1; wrAddr1 = 30; wrData1 = 32'h0BADF00D;
    busySet = 1'b1; busySetAddr = 30;
    setRd(2, 30);
    tick();
    idle();
    #1;
    vectors++;
    if (rdData[2*DW +: DW] !== 32'h0 || rdBusy[2] !== 1'b0 || wbValid !== 1'b0) begin
      miscompares++;
      $display("FAIL out_of_range: got data %h busy %b wbValid %b, expected 0/0/0", rdData[2*DW +: DW], rdBusy[2], wbValid);
    end
  endtask

  task automatic test_scoreboard();
    busySet = 1'b1; busySetAddr = 9;
    setRd(0, 9);
    tick();
    idle();
    #1;
    vectors++;
    if (rdBusy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_set: got busy %b, expected 1", rdBusy[0]);
    end
    busySet = 1'b1;  // re-issue to an already busy register
    tick();
    idle();
    wrEn0 = 1'b1; wrAddr0 = 9; wrData0 = 32'h1;
    tick();
    idle();
    #1;
    vectors++;
    if (rdBusy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_clear_after_double_set: got busy %b, expected 0", rdBusy[0]);
    end
    busySet = 1'b1; busySetAddr = 9;
    wrEn1 = 1'b1; wrAddr1 = 9; wrData1 = 32'h2;
    tick();
    idle();
    #1;
    vectors++;
    if (rdBusy[0] !== 1'b1 || rdData[0 +: DW] !== 32'h2) begin
      miscompares++;
      $display("FAIL sb_set_beats_clear: got busy %b data %h, expected 1 / 00000002", rdBusy[0], rdData[0 +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] ed;
    bit            eb;
    wrEn0 = 1'b1; wrAddr0 = 4; wrData0 = 32'h1111;
    tick();
    idle();
    wrEn0 = 1'b1; wrAddr0 = 4; wrData0 = 32'hCAFE;
    setRd(0, 4);
    #1;
    vectors++;
`ifdef REGFILE_BYPASS_EN
    if (rdData[0 +: DW] !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h, expected 0000cafe", rdData[0 +: DW]);
    end
`else
    if (rdData[0 +: DW] !== 32'h1111) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h, expected 00001111", rdData[0 +: DW]);
    end
`endif
    tick();
    idle();
    #1;
    vectors++;
    if (rdData[0 +: DW] !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL bypass_next_cycle: got %h, expected 0000cafe", rdData[0 +: DW]);
    end
    // Same-cycle write plus re-issue of the same register.
    wrEn1 = 1'b1; wrAddr1 = 4; wrData1 = 32'hBEEF;
    busySet = 1'b1; busySetAddr = 4;
    #1;
    expRead(5'd4, ed, eb);
    vectors++;
    if (rdData[0 +: DW] !== ed || rdBusy[0] !== eb) begin
      miscompares++;
      $display("FAIL bypass_busy: got data %h busy %b, expected %h / %b", rdData[0 +: DW], rdBusy[0], ed, eb);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    bit            eb;
    for (int n = 0; n < 300; n++) begin
      bit narrow;
      narrow  = ($urandom_range(0, 3) == 0);
      wrEn0   = 1'($urandom_range(0, 1));
      wrEn1   = 1'($urandom_range(0, 1));
      busySet = 1'($urandom_range(0, 1));
      wrAddr0     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wrAddr1     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      busySetAddr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wrData0 = $urandom;
      wrData1 = $urandom;
      for (int k = 0; k < NR; k++) begin
        setRd(k, narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)));
      end
      #1;
      for (int k = 0; k < NR; k++) begin
        expRead(rdAddr[k*AW +: AW], ed, eb);
        vectors++;
        if (rdData[k*DW +: DW] !== ed || rdBusy[k] !== eb) begin
          miscompares++;
          $display("FAIL rand_read cycle %0d port %0d addr %0d: got data %h busy %b, expected %h / %b",
                   n, k, rdAddr[k*AW +: AW], rdData[k*DW +: DW], rdBusy[k], ed, eb);
        end
      end
      tick();
      vectors++;
      if (wbValid !== mWbV || wbReg !== mWbR || wbVal !== mWbD) begin
        miscompares++;
        $display("FAIL rand_wb cycle %0d: got valid %b reg %0d val %h, expected %b / %0d / %h",
                 n, wbValid, wbReg, wbVal, mWbV, mWbR, mWbD);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    tick();
    test_basic_write();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
